// File: rtl/disp_window_mixer.sv
// rtl/disp_window_mixer.sv - multi-window compositor: hit test, FIFO reads, priority select, border, background
module disp_window_mixer #(
    parameter int N_WIN    = 2,
    parameter int COORD_W  = 11,
    parameter int PIX_W    = 16,
    parameter int BORDER_W = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          vsync_i,
    input  logic                          req_valid_i,
    input  logic [COORD_W-1:0]            req_x_i,
    input  logic [COORD_W-1:0]            req_y_i,
    input  logic [N_WIN-1:0]              cfg_en_i,
    input  logic [N_WIN*COORD_W-1:0]      cfg_x_i,
    input  logic [N_WIN*COORD_W-1:0]      cfg_y_i,
    input  logic [N_WIN*COORD_W-1:0]      cfg_w_i,
    input  logic [N_WIN*COORD_W-1:0]      cfg_h_i,
    input  logic [PIX_W-1:0]              bg_color_i,
    input  logic [PIX_W-1:0]              border_color_i,
    output logic [N_WIN-1:0]              win_rd_req_o,
    input  logic [N_WIN*PIX_W-1:0]        win_rd_data_i,
    output logic [PIX_W-1:0]              data_out_o,
    output logic                          data_valid_o,
    output logic [$clog2(N_WIN+1)-1:0]    sel_id_o,
    output logic                          frame_start_o
);

    localparam int                SEL_W  = $clog2(N_WIN + 1);
    localparam logic [SEL_W-1:0]  BG_SEL = SEL_W'(N_WIN);
    localparam logic [COORD_W:0]  BW     = (COORD_W + 1)'(BORDER_W);

    logic                     vsync_q;
    logic [N_WIN-1:0]         sh_en_q;
    logic [N_WIN*COORD_W-1:0] sh_x_q, sh_y_q, sh_w_q, sh_h_q;
    logic                     load;

    logic [N_WIN-1:0]         hit;
    logic [N_WIN-1:0]         border;
    logic [SEL_W-1:0]         win_d, win1_q;
    logic                     bord_d, bord1_q;
    logic                     vld1_q;

    logic [PIX_W-1:0]         fifo_pix;
    logic [PIX_W-1:0]         pix_d;
    logic [PIX_W-1:0]         data_out_q;
    logic                     data_valid_q;
    logic [SEL_W-1:0]         sel_q;

    // Rising edge of vsync opens a new frame; gated so the pulse is low while in reset.
    assign load          = vsync_i & ~vsync_q;
    assign frame_start_o = load & rst_n;

    // Shadow geometry only changes at frame start so a frame is composed from one consistent set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            sh_en_q <= '0;
            sh_x_q  <= '0;
            sh_y_q  <= '0;
            sh_w_q  <= '0;
            sh_h_q  <= '0;
        end else begin
            vsync_q <= vsync_i;
            if (load) begin
                sh_en_q <= cfg_en_i;
                sh_x_q  <= cfg_x_i;
                sh_y_q  <= cfg_y_i;
                sh_w_q  <= cfg_w_i;
                sh_h_q  <= cfg_h_i;
            end
        end
    end

    // Per-window hit and border test; far edges use one extra bit so windows clip instead of wrapping.
    always_comb begin
        logic [COORD_W:0] x0, y0, x_end, y_end, rx, ry;
        hit    = '0;
        border = '0;
        x0     = '0;
        y0     = '0;
        x_end  = '0;
        y_end  = '0;
        rx     = {1'b0, req_x_i};
        ry     = {1'b0, req_y_i};
        for (int i = 0; i < N_WIN; i++) begin
            x0        = {1'b0, sh_x_q[i*COORD_W +: COORD_W]};
            y0        = {1'b0, sh_y_q[i*COORD_W +: COORD_W]};
            x_end     = x0 + {1'b0, sh_w_q[i*COORD_W +: COORD_W]};
            y_end     = y0 + {1'b0, sh_h_q[i*COORD_W +: COORD_W]};
            hit[i]    = sh_en_q[i] && (rx >= x0) && (rx < x_end) && (ry >= y0) && (ry < y_end);
            border[i] = ((rx - x0) < BW) || ((x_end - rx) <= BW) ||
                        ((ry - y0) < BW) || ((y_end - ry) <= BW);
        end
    end

    // Every covering window is read, hidden or not, so each FIFO drains exactly its own area.
    assign win_rd_req_o = {N_WIN{req_valid_i}} & hit;

    // Lowest-index hit wins; background index when nothing covers the pixel.
    always_comb begin
        win_d  = BG_SEL;
        bord_d = 1'b0;
        for (int i = N_WIN - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_d  = SEL_W'(i);
                bord_d = border[i];
            end
        end
    end

    // Stage 1 holds the decision while the FIFO word arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1_q  <= 1'b0;
            win1_q  <= '0;
            bord1_q <= 1'b0;
        end else begin
            vld1_q  <= req_valid_i;
            win1_q  <= win_d;
            bord1_q <= bord_d;
        end
    end

    // Pick the winner's FIFO word and apply border/background replacement.
    always_comb begin
        fifo_pix = '0;
        for (int i = 0; i < N_WIN; i++) begin
            if (win1_q == SEL_W'(i)) begin
                fifo_pix = win_rd_data_i[i*PIX_W +: PIX_W];
            end
        end
        if (win1_q == BG_SEL) begin
            pix_d = bg_color_i;
        end else if (bord1_q) begin
            pix_d = border_color_i;
        end else begin
            pix_d = fifo_pix;
        end
    end

    // Stage 2 output registers; pixel and source hold when no request is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            sel_q        <= '0;
        end else begin
            data_valid_q <= vld1_q;
            if (vld1_q) begin
                data_out_q <= pix_d;
                sel_q      <= win1_q;
            end
        end
    end

    assign data_out_o   = data_out_q;
    assign data_valid_o = data_valid_q;
    assign sel_id_o     = sel_q;

endmodule

// File: tb/tb_disp_window_mixer.sv
// tb/tb_disp_window_mixer.sv - scoreboard bench for disp_window_mixer (borderless and 2-pixel border instances)
module tb_disp_window_mixer;

    localparam logic [15:0] BG  = 16'h1234;
    localparam logic [15:0] BRD = 16'hF00F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        req_valid = 1'b0;
    logic [10:0] req_x = '0, req_y = '0;
    logic [1:0]  cfg_en = '0;
    logic [21:0] cfg_x = '0, cfg_y = '0, cfg_w = '0, cfg_h = '0;

    logic [1:0]  rd_a, rd_b;
    logic [31:0] rd_data_a = '0, rd_data_b = '0;
    logic [15:0] dout_a, dout_b;
    logic        dv_a, dv_b, fs_a, fs_b;
    logic [1:0]  sel_a, sel_b;

    logic [15:0] cnt_a [2] = '{16'd0, 16'd0};
    logic [15:0] cnt_b [2] = '{16'd0, 16'd0};
    logic [15:0] exp_cnt [2] = '{16'd0, 16'd0};

    logic [17:0] qa [$];
    logic [17:0] qb [$];
    logic [17:0] last_a = '0, last_b = '0, ea, eb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    disp_window_mixer #(.N_WIN(2), .COORD_W(11), .PIX_W(16), .BORDER_W(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync), .req_valid_i(req_valid),
        .req_x_i(req_x), .req_y_i(req_y), .cfg_en_i(cfg_en),
        .cfg_x_i(cfg_x), .cfg_y_i(cfg_y), .cfg_w_i(cfg_w), .cfg_h_i(cfg_h),
        .bg_color_i(BG), .border_color_i(BRD), .win_rd_req_o(rd_a),
        .win_rd_data_i(rd_data_a), .data_out_o(dout_a), .data_valid_o(dv_a),
        .sel_id_o(sel_a), .frame_start_o(fs_a)
    );

    disp_window_mixer #(.N_WIN(2), .COORD_W(11), .PIX_W(16), .BORDER_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync), .req_valid_i(req_valid),
        .req_x_i(req_x), .req_y_i(req_y), .cfg_en_i(cfg_en),
        .cfg_x_i(cfg_x), .cfg_y_i(cfg_y), .cfg_w_i(cfg_w), .cfg_h_i(cfg_h),
        .bg_color_i(BG), .border_color_i(BRD), .win_rd_req_o(rd_b),
        .win_rd_data_i(rd_data_b), .data_out_o(dout_b), .data_valid_o(dv_b),
        .sel_id_o(sel_b), .frame_start_o(fs_b)
    );

    function automatic logic [15:0] base(input int i);
        return 16'((i + 1) * 16'h4000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // FIFO models: each read returns base + running word count one cycle later.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_a[i]) begin
                rd_data_a[i*16 +: 16] <= base(i) + cnt_a[i];
                cnt_a[i] <= cnt_a[i] + 16'd1;
            end
            if (rd_b[i]) begin
                rd_data_b[i*16 +: 16] <= base(i) + cnt_b[i];
                cnt_b[i] <= cnt_b[i] + 16'd1;
            end
        end
    end

    // Monitor: pops the scoreboard on every valid output, checks hold/reset otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_a = '0;
            last_b = '0;
            chk("rst_out_a", 32'({dv_a, dout_a, sel_a}), 32'd0);
            chk("rst_out_b", 32'({dv_b, dout_b, sel_b}), 32'd0);
        end else begin
            if (dv_a) begin
                if (qa.size() == 0) chk("unexpected_valid_a", 32'd1, 32'd0);
                else begin
                    ea = qa.pop_front();
                    chk("pix_a", 32'(dout_a), 32'(ea[17:2]));
                    chk("sel_a", 32'(sel_a), 32'(ea[1:0]));
                    last_a = ea;
                end
            end else begin
                chk("hold_a", 32'({dout_a, sel_a}), 32'(last_a));
            end
            if (dv_b) begin
                if (qb.size() == 0) chk("unexpected_valid_b", 32'd1, 32'd0);
                else begin
                    eb = qb.pop_front();
                    chk("pix_b", 32'(dout_b), 32'(eb[17:2]));
                    chk("sel_b", 32'(sel_b), 32'(eb[1:0]));
                    last_b = eb;
                end
            end else begin
                chk("hold_b", 32'({dout_b, sel_b}), 32'(last_b));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        #1;
        chk("idle_rd_a", 32'(rd_a), 32'd0);
        chk("idle_rd_b", 32'(rd_b), 32'd0);
    endtask

    task automatic issue(input int x, input int y, input logic [1:0] rd, input int sel, input bit bord);
        logic [15:0] val [2];
        logic [15:0] da, db;
        req_valid = 1'b1;
        req_x = 11'(x);
        req_y = 11'(y);
        #1;
        chk("rd_a", 32'(rd_a), 32'(rd));
        chk("rd_b", 32'(rd_b), 32'(rd));
        for (int i = 0; i < 2; i++) begin
            val[i] = base(i) + exp_cnt[i];
            if (rd[i]) exp_cnt[i] = exp_cnt[i] + 16'd1;
        end
        if (sel == 2) begin
            da = BG;
            db = BG;
        end else begin
            da = val[sel];
            db = bord ? BRD : val[sel];
        end
        qa.push_back({da, 2'(sel)});
        qb.push_back({db, 2'(sel)});
    endtask

    task automatic set_win(input int i, input int x, input int y, input int w, input int h);
        cfg_x[i*11 +: 11] = 11'(x);
        cfg_y[i*11 +: 11] = 11'(y);
        cfg_w[i*11 +: 11] = 11'(w);
        cfg_h[i*11 +: 11] = 11'(h);
    endtask

    task automatic load_frame();
        cyc();
        vsync = 1'b1;
        #1;
        chk("fs_load_a", 32'(fs_a), 32'd1);
        chk("fs_load_b", 32'(fs_b), 32'd1);
        cyc();
        chk("fs_held_a", 32'(fs_a), 32'd0);
        vsync = 1'b0;
    endtask

    logic [1:0] ov_rd  [6] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10};
    int         ov_sel [6] = '{0, 0, 0, 0, 1, 1};
    int         cl_x   [5] = '{2039, 2040, 2047, 0, 5};
    logic [1:0] cl_rd  [5] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    int         cl_sel [5] = '{2, 0, 0, 2, 2};

    initial begin
        #1;
        chk("reset_a", 32'({fs_a, rd_a, dv_a, dout_a, sel_a}), 32'd0);
        chk("reset_b", 32'({fs_b, rd_b, dv_b, dout_b, sel_b}), 32'd0);
        repeat (2) cyc();
        rst_n = 1'b1;

        // Left edge sweep, borderless vs bordered top row.
        set_win(0, 100, 100, 640, 480);
        set_win(1, 0, 0, 0, 0);
        cfg_en = 2'b01;
        load_frame();
        for (int x = 98; x <= 102; x++) begin
            cyc();
            issue(x, 100, (x >= 100) ? 2'b01 : 2'b00, (x >= 100) ? 0 : 2, 1'b1);
        end
        cyc(); idle();
        cyc(); idle();

        // Overlap: hidden window still read.
        set_win(0, 0, 0, 4, 1);
        set_win(1, 2, 0, 4, 1);
        cfg_en = 2'b11;
        load_frame();
        for (int x = 0; x < 6; x++) begin
            cyc();
            issue(x, 0, ov_rd[x], ov_sel[x], 1'b1);
        end
        cyc(); idle();

        // Border region of an 8x8 window.
        set_win(0, 10, 10, 8, 8);
        cfg_en = 2'b01;
        load_frame();
        cyc(); issue(10, 10, 2'b01, 0, 1'b1);
        cyc(); issue(12, 12, 2'b01, 0, 1'b0);
        cyc(); issue(17, 17, 2'b01, 0, 1'b1);
        cyc(); issue(16, 13, 2'b01, 0, 1'b1);
        cyc(); issue(15, 15, 2'b01, 0, 1'b0);
        cyc(); idle();

        // Shadow timing.
        set_win(0, 100, 100, 640, 480);
        load_frame();
        cyc(); issue(150, 200, 2'b01, 0, 1'b0);
        set_win(0, 200, 100, 640, 480);
        cyc(); issue(150, 200, 2'b01, 0, 1'b0);
        cyc();
        vsync = 1'b1;
        issue(150, 200, 2'b01, 0, 1'b0);
        chk("fs_edge_a", 32'(fs_a), 32'd1);
        chk("fs_edge_b", 32'(fs_b), 32'd1);
        cyc(); issue(150, 200, 2'b00, 2, 1'b0);
        chk("fs_after_a", 32'(fs_a), 32'd0);
        set_win(0, 100, 100, 640, 480);
        cyc(); issue(150, 200, 2'b00, 2, 1'b0);
        cyc(); issue(250, 200, 2'b01, 0, 1'b0);
        chk("fs_hold_high_b", 32'(fs_b), 32'd0);
        vsync = 1'b0;
        cyc(); idle();

        // Clipping at the coordinate limit and zero-width window.
        set_win(0, 2040, 0, 100, 1);
        set_win(1, 0, 0, 0, 1);
        cfg_en = 2'b11;
        load_frame();
        for (int k = 0; k < 5; k++) begin
            cyc();
            issue(cl_x[k], 0, cl_rd[k], cl_sel[k], 1'b1);
        end

        // Reset during active requests.
        cyc(); issue(2040, 0, 2'b01, 0, 1'b1);
        cyc(); issue(2041, 0, 2'b01, 0, 1'b1);
        cyc();
        rst_n = 1'b0;
        req_x = 11'd2042;
        #1;
        chk("midrst_a", 32'({fs_a, rd_a, dv_a, dout_a, sel_a}), 32'd0);
        chk("midrst_b", 32'({fs_b, rd_b, dv_b, dout_b, sel_b}), 32'd0);
        qa.delete();
        qb.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
        idle();
        cyc(); issue(2040, 0, 2'b00, 2, 1'b0);
        cyc(); issue(12, 0, 2'b00, 2, 1'b0);
        cyc(); idle();
        repeat (4) cyc();
        chk("drain_a", 32'(qa.size()), 32'd0);
        chk("drain_b", 32'(qb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
